// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared constants and state type for the IIR coefficient loader
package iir_pkg;

  localparam int COEFF_WIDTH_DEF = 32;
  localparam int NUM_COEFFS      = 6;

  localparam logic [2:0] ADDR_B0   = 3'd0;
  localparam logic [2:0] ADDR_B1   = 3'd1;
  localparam logic [2:0] ADDR_B2   = 3'd2;
  localparam logic [2:0] ADDR_A1   = 3'd3;
  localparam logic [2:0] ADDR_A2   = 3'd4;
  localparam logic [2:0] ADDR_GAIN = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/iir_coeff_loader.sv
// rtl/iir_coeff_loader.sv - shadowed biquad coefficient bank applied on a sample boundary
// Optional registered readback port enabled by IIR_COEFF_READBACK_EN.
module iir_coeff_loader
  import iir_pkg::*;
#(
  parameter int COEFF_WIDTH  = COEFF_WIDTH_DEF,
  parameter int TICK_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [2:0]                    wr_addr,
  input  logic signed [COEFF_WIDTH-1:0] wr_data,
  input  logic                          commit,
  input  logic                          sample_tick,
  input  logic                          clr_err,
`ifdef IIR_COEFF_READBACK_EN
  input  logic [2:0]                    rd_addr,
  input  logic                          rd_shadow,
  output logic [COEFF_WIDTH-1:0]        rd_data,
`endif
  output logic signed [COEFF_WIDTH-1:0] b0,
  output logic signed [COEFF_WIDTH-1:0] b1,
  output logic signed [COEFF_WIDTH-1:0] b2,
  output logic signed [COEFF_WIDTH-1:0] a1,
  output logic signed [COEFF_WIDTH-1:0] a2,
  output logic signed [COEFF_WIDTH-1:0] gain,
  output logic                          busy,
  output logic                          commit_done,
  output logic                          err_addr,
  output logic                          err_incomplete,
  output logic                          err_busy,
  output logic                          timeout
);

  localparam int CNT_W = (TICK_TIMEOUT > 2) ? $clog2(TICK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_TIMEOUT - 1);

  state_t state, state_next;

  logic [COEFF_WIDTH-1:0] shadow [NUM_COEFFS];
  logic [COEFF_WIDTH-1:0] active [NUM_COEFFS];
  logic [NUM_COEFFS-1:0]  mask;
  logic [NUM_COEFFS-1:0]  wr_bit;
  logic [CNT_W-1:0]       cnt;
  logic                   forced;

  logic addr_ok, addr_bad;
  logic do_commit, forced_hit, busy_hit, incomplete_hit;

  assign addr_ok  = wr_addr <= ADDR_GAIN;
  assign addr_bad = wr_en && !addr_ok;
  // Shadows only accept data while idle; the bank is frozen once armed.
  assign wr_bit   = (wr_en && addr_ok && state == ST_IDLE) ? (NUM_COEFFS'(1) << wr_addr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    do_commit      = 1'b0;
    forced_hit     = 1'b0;
    busy_hit       = 1'b0;
    incomplete_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (commit) begin
          if ((mask | wr_bit) == '1) state_next = ST_ARMED;
          else                       incomplete_hit = 1'b1;
        end
      end
      ST_ARMED: begin
        busy_hit = wr_en || commit;
        if (sample_tick) begin
          state_next = ST_COMMIT;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_COMMIT;
          forced_hit = 1'b1;
        end
      end
      ST_COMMIT: begin
        busy_hit   = wr_en || commit;
        do_commit  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEFFS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      mask           <= '0;
      cnt            <= '0;
      forced         <= 1'b0;
      commit_done    <= 1'b0;
      err_addr       <= 1'b0;
      err_incomplete <= 1'b0;
      err_busy       <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_COEFFS; i++) begin
        if (wr_bit[i]) shadow[i] <= wr_data;
        if (do_commit) active[i] <= shadow[i];
      end
      mask        <= do_commit ? '0 : (mask | wr_bit);
      cnt         <= (state == ST_ARMED) ? cnt + CNT_W'(1) : '0;
      // Remember why ARMED was left so the timeout flag lands with commit_done.
      if (state == ST_ARMED) forced <= forced_hit;
      commit_done <= do_commit;
      err_addr       <= !clr_err && (err_addr || addr_bad);
      err_incomplete <= !clr_err && (err_incomplete || incomplete_hit);
      err_busy       <= !clr_err && (err_busy || busy_hit);
      timeout        <= !clr_err && (timeout || (do_commit && forced));
    end
  end

`ifdef IIR_COEFF_READBACK_EN
  logic [COEFF_WIDTH-1:0] rd_next;

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_COEFFS; i++) begin
      if (rd_addr == 3'(i)) rd_next = rd_shadow ? shadow[i] : active[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_next;
  end
`endif

  assign busy = (state == ST_ARMED);
  assign b0   = active[ADDR_B0];
  assign b1   = active[ADDR_B1];
  assign b2   = active[ADDR_B2];
  assign a1   = active[ADDR_A1];
  assign a2   = active[ADDR_A2];
  assign gain = active[ADDR_GAIN];

endmodule

// File: tb/tb_iir_coeff_loader.sv
// tb/tb_iir_coeff_loader.sv - directed self-checking bench for iir_coeff_loader
module tb_iir_coeff_loader;

  localparam int W = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wr_en = 1'b0;
  logic [2:0]         wr_addr = '0;
  logic signed [W-1:0] wr_data = '0;
  logic               commit = 1'b0;
  logic               sample_tick = 1'b0;
  logic               clr_err = 1'b0;
  logic signed [W-1:0] b0, b1, b2, a1, a2, gain;
  logic               busy, commit_done, err_addr, err_incomplete, err_busy, timeout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  iir_coeff_loader #(.COEFF_WIDTH(W), .TICK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .sample_tick(sample_tick), .clr_err(clr_err),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .gain(gain),
    .busy(busy), .commit_done(commit_done), .err_addr(err_addr),
    .err_incomplete(err_incomplete), .err_busy(err_busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (commit_done) done_cnt++;

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_coeff(input logic [2:0] addr, input logic signed [W-1:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_set(input logic signed [W-1:0] v0, v1, v2, v3, v4, v5);
    write_coeff(3'd0, v0);
    write_coeff(3'd1, v1);
    write_coeff(3'd2, v2);
    write_coeff(3'd3, v3);
    write_coeff(3'd4, v4);
    write_coeff(3'd5, v5);
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b0, b1, b2, a1, a2, gain} !== '0) begin
      $display("FAIL reset_outputs: got %h want 0", {b0, b1, b2, a1, a2, gain});
      errors++;
    end
    checks++;
    if ({busy, commit_done, err_addr, err_incomplete, err_busy, timeout} !== 6'b0) begin
      $display("FAIL reset_status: got %b want 000000",
               {busy, commit_done, err_addr, err_incomplete, err_busy, timeout});
      errors++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_incomplete();
    do_reset();
    write_coeff(3'd0, 1);
    write_coeff(3'd1, 2);
    write_coeff(3'd2, 3);
    write_coeff(3'd3, 4);
    write_coeff(3'd4, 5);
    pulse_commit();
    checks++;
    if (err_incomplete !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL incomplete_flag: got err=%b busy=%b want err=1 busy=0", err_incomplete, busy);
      errors++;
    end
    pulse_tick();
    @(negedge clk);
    checks++;
    if ({b0, b1, b2, a1, a2, gain} !== '0) begin
      $display("FAIL incomplete_outputs: got %h want 0", {b0, b1, b2, a1, a2, gain});
      errors++;
    end
    // Completing the last slot must arm with the earlier shadows intact.
    write_coeff(3'd5, 6);
    pulse_commit();
    pulse_tick();
    @(negedge clk);
    checks++;
    if ({b0, b1, b2, a1, a2, gain} !== {32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6}) begin
      $display("FAIL incomplete_shadow_kept: got %h want 1..6", {b0, b1, b2, a1, a2, gain});
      errors++;
    end
  endtask

  task automatic test_full_load();
    int d0;
    do_reset();
    d0 = done_cnt;
    load_set(100, 200, 300, 40, 50, 16384);
    pulse_commit();
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL full_armed: got busy=%b want 1", busy);
      errors++;
    end
    repeat (4) @(negedge clk);
    pulse_tick();
    checks++;
    if (b0 !== 0 || commit_done !== 1'b0) begin
      $display("FAIL full_latency1: got b0=%0d done=%b want b0=0 done=0", b0, commit_done);
      errors++;
    end
    @(negedge clk);
    checks++;
    if ({b0, b1, b2, a1, a2, gain} !==
        {32'sd100, 32'sd200, 32'sd300, 32'sd40, 32'sd50, 32'sd16384} || commit_done !== 1'b1) begin
      $display("FAIL full_latency2: got %h done=%b want 100,200,300,40,50,16384 done=1",
               {b0, b1, b2, a1, a2, gain}, commit_done);
      errors++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || commit_done !== 1'b0 || timeout !== 1'b0) begin
      $display("FAIL full_single_pulse: got pulses=%0d done=%b timeout=%b want 1 0 0",
               done_cnt - d0, commit_done, timeout);
      errors++;
    end
  endtask

  task automatic test_busy();
    do_reset();
    load_set(11, 12, 13, 14, 15, 16);
    pulse_commit();
    write_coeff(3'd0, 7);
    checks++;
    if (err_busy !== 1'b1) begin
      $display("FAIL busy_flag: got %b want 1", err_busy);
      errors++;
    end
    pulse_tick();
    @(negedge clk);
    checks++;
    if (b0 !== 11 || gain !== 16) begin
      $display("FAIL busy_frozen: got b0=%0d gain=%0d want 11 16", b0, gain);
      errors++;
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (err_busy !== 1'b0) begin
      $display("FAIL busy_clear: got %b want 0", err_busy);
      errors++;
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    load_set(21, 22, 23, 24, 25, 26);
    pulse_commit();
    n = 0;
    while (!commit_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 17) begin
      $display("FAIL timeout_cycles: got %0d want 17", n);
      errors++;
    end
    checks++;
    if (timeout !== 1'b1 || b0 !== 21 || gain !== 26) begin
      $display("FAIL timeout_commit: got timeout=%b b0=%0d gain=%0d want 1 21 26", timeout, b0, gain);
      errors++;
    end
  endtask

  task automatic test_reset_armed();
    int d0;
    do_reset();
    load_set(1, 2, 3, 4, 5, 6);
    pulse_commit();
    pulse_tick();
    @(negedge clk);
    checks++;
    if (b0 !== 1) begin
      $display("FAIL rst_armed_pre: got b0=%0d want 1", b0);
      errors++;
    end
    load_set(9, 9, 9, 9, 9, 9);
    pulse_commit();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b0, b1, b2, a1, a2, gain} !== '0 || busy !== 1'b0) begin
      $display("FAIL rst_armed_async: got %h busy=%b want 0 0", {b0, b1, b2, a1, a2, gain}, busy);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    pulse_tick();
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || b0 !== 0 || busy !== 1'b0) begin
      $display("FAIL rst_armed_abandon: got pulses=%0d b0=%0d busy=%b want 0 0 0",
               done_cnt - d0, b0, busy);
      errors++;
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    load_set(5, 6, 7, 8, 9, 10);
    pulse_commit();
    pulse_tick();
    @(negedge clk);
    write_coeff(3'd7, 32'hDEAD);
    checks++;
    if (err_addr !== 1'b1 || {b0, b1, b2, a1, a2, gain} !==
        {32'sd5, 32'sd6, 32'sd7, 32'sd8, 32'sd9, 32'sd10}) begin
      $display("FAIL bad_addr_flag: got err=%b out=%h want 1 5..10", err_addr, {b0, b1, b2, a1, a2, gain});
      errors++;
    end
    // The bad write must not have marked any slot written.
    pulse_commit();
    checks++;
    if (err_incomplete !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL bad_addr_mask: got inc=%b busy=%b want 1 0", err_incomplete, busy);
      errors++;
    end
    clr_err = 1'b1;
    write_coeff(3'd6, 32'hBEEF);
    clr_err = 1'b0;
    checks++;
    if (err_addr !== 1'b0 || err_incomplete !== 1'b0) begin
      $display("FAIL bad_addr_clr_dominates: got err_addr=%b inc=%b want 0 0", err_addr, err_incomplete);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_set(-1, -2, -3, -4, -5, -32768);
    commit = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || commit_done !== 1'b0) begin
      $display("FAIL b2b_entry_tick_ignored: got busy=%b done=%b want 1 0", busy, commit_done);
      errors++;
    end
    pulse_tick();
    @(negedge clk);
    checks++;
    if ({b0, b1, b2, a1, a2, gain} !==
        {-32'sd1, -32'sd2, -32'sd3, -32'sd4, -32'sd5, -32'sd32768}) begin
      $display("FAIL b2b_first: got %h want -1,-2,-3,-4,-5,-32768", {b0, b1, b2, a1, a2, gain});
      errors++;
    end
    load_set(31, 32, 33, 34, 35, 36);
    pulse_commit();
    pulse_tick();
    @(negedge clk);
    checks++;
    if ({b0, b1, b2, a1, a2, gain} !== {32'sd31, 32'sd32, 32'sd33, 32'sd34, 32'sd35, 32'sd36}) begin
      $display("FAIL b2b_second: got %h want 31..36", {b0, b1, b2, a1, a2, gain});
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_incomplete();
    test_full_load();
    test_busy();
    test_timeout();
    test_reset_armed();
    test_bad_addr();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_coeff_loader.md
IIR_COEFF_LOADER -- requirements
Module: iir_coeff_loader

Interface
REQ-001 SHALL have parameter COEFF_WIDTH, default 32: width of every coefficient word.
REQ-002 SHALL have parameter TICK_TIMEOUT, default 1024: clock cycles ARMED waits for sample_tick before a forced commit.
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
REQ-004 SHALL have these data and handshake ports:
- wr_en  in  1  shadow write strobe
- wr_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2, 5=gain; 6 and 7 invalid
- wr_data  in  COEFF_WIDTH  signed write value
- commit  in  1  single-cycle request to apply the shadow set
- sample_tick  in  1  filter sample-boundary strobe
REQ-005 SHALL have these coefficient outputs: b0, b1, b2, a1, a2, gain, each out, COEFF_WIDTH wide, signed, holding the active coefficient set.
REQ-006 SHALL have these status outputs:
- busy  out  1  high while ARMED
- commit_done  out  1  one-cycle pulse when active registers update
- err_addr  out  1  sticky; set by a write to address 6 or 7
- err_incomplete  out  1  sticky; set by a commit with the shadow set incomplete
- err_busy  out  1  sticky; set by a write or commit while ARMED
- timeout  out  1  sticky; set by a forced commit
- clr_err  in  1  clears all sticky flags

Function
REQ-007 SHALL keep six shadow registers and a 6-bit written-mask. A write to a valid address updates that shadow and its mask bit on the same clock edge.
REQ-008 SHALL use a state machine with three states: IDLE, ARMED, COMMIT.
- IDLE to ARMED: on commit when mask==6'b111111, with the mask evaluated including any same-cycle write.
- ARMED to COMMIT: on sample_tick, or when the timeout counter reaches TICK_TIMEOUT-1.
- COMMIT to IDLE: unconditional, after one cycle.
REQ-009 SHALL, in COMMIT, copy all six shadows into the active outputs on a single edge. commit_done SHALL be high for exactly that cycle, and the mask SHALL clear to 0.
REQ-010 SHALL give a latency of 2 clocks from the cycle sample_tick is sampled high in ARMED to the cycle the updated outputs are visible.
REQ-011 SHALL, on commit in IDLE with an incomplete mask, set err_incomplete and stay in IDLE; the shadows and mask are untouched.
REQ-012 SHALL, in ARMED and COMMIT, ignore writes and commit requests and set err_busy; the shadows stay frozen.
REQ-013 SHALL, on a write to address 6 or 7, set err_addr and change no register.
REQ-014 SHALL reset the timeout counter on entering ARMED. On a forced commit, SHALL set timeout in the same cycle as commit_done.
REQ-015 SHALL let a sample_tick in the same cycle the state enters ARMED not count; only ticks sampled while ARMED count.
REQ-016 SHALL make clr_err dominate a same-cycle flag set: the flag ends cleared.
REQ-017 SHALL never change the active outputs except in COMMIT.

Reset
REQ-018 SHALL, on rst_n low, asynchronously clear:
- all active outputs, shadows, mask, counter and flags to 0
- commit_done to 0
- state to IDLE
REQ-019 SHALL, when reset is asserted during ARMED, abandon the pending commit; the active set reads 0 after release.

Configuration
REQ-020 SHALL support macro IIR_COEFF_READBACK_EN. When defined, SHALL add:
- rd_addr  in  3  readback address
- rd_shadow  in  1  selects shadow (1) or active (0) bank
- rd_data  out  COEFF_WIDTH  registered readback, 1-cycle latency; 0 for address 6 or 7
When undefined, these ports and their logic SHALL be absent.

Structure
REQ-021 SHALL place the following in shared package iir_pkg:
- the COEFF_WIDTH default
- the address constants ADDR_B0..ADDR_GAIN
- the state typedef
REQ-022 SHALL be flat; no sub-module is required.

Verification
REQ-023 Write 100, 200, 300, 40, 50, 16384 to addresses 0..5, commit, then sample_tick 5 cycles later:
- outputs update 2 cycles after the tick
- commit_done pulses once
REQ-024 Write addresses 0..4 only, then commit:
- err_incomplete=1, state stays IDLE
- outputs stay 0
REQ-025 Load a full set and commit, then write addr 0 = 7 while ARMED:
- err_busy=1
- after the tick, b0 equals the pre-ARMED value
REQ-026 Load a full set, commit, no sample_tick, TICK_TIMEOUT=16:
- forced commit 16 cycles after entry to ARMED
- timeout=1 with commit_done
REQ-027 Load a full set, commit, then assert rst_n low for 1 cycle during ARMED:
- all outputs 0, state IDLE
- a following sample_tick causes no commit_done
REQ-028 Write addr 7 = 0xDEAD:
- err_addr=1, no register changes
- then clr_err asserted with a same-cycle bad write leaves err_addr=0
